// File: rtl/fpadd_share_arb.sv
// Shares one pipelined FP adder between the RISC5 core (port 0) and a coprocessor (port 1).
// Arbitrates, latches operands, sequences run/stall, and aborts a hung adder via a watchdog.
module fpadd_share_arb #(
    parameter int MAX_WAIT   = 15,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic [1:0]  r0_op,
    input  logic [31:0] r0_x,
    input  logic [31:0] r0_y,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic [1:0]  r1_op,
    input  logic [31:0] r1_x,
    input  logic [31:0] r1_y,
    output logic        r1_ack,
    output logic [31:0] res,
    output logic        err,
    output logic        fa_run,
    output logic        fa_u,
    output logic        fa_v,
    output logic [31:0] fa_x,
    output logic [31:0] fa_y,
    input  logic        fa_stall,
    input  logic [31:0] fa_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REJ  = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic        elig0;
    logic        elig1;
    logic        anyReq;
    logic        pick;
    logic        grantId;
    logic        lastServed;
    logic        finish;
    logic        finishErr;
    logic [1:0]  selOp;
    logic [31:0] selX;
    logic [31:0] selY;
    logic [7:0]  waitCnt;

    // A port whose ack is high this cycle is still holding req from the op just finished.
    assign elig0  = r0_req & ~r0_ack;
    assign elig1  = r1_req & ~r1_ack;
    assign anyReq = elig0 | elig1;
    assign pick   = (elig0 & elig1) ? (PRIO_FIXED ? 1'b0 : ~lastServed) : elig1;
    assign selOp  = pick ? r1_op : r0_op;
    assign selX   = pick ? r1_x : r0_x;
    assign selY   = pick ? r1_y : r0_y;
    assign fa_run = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = (selOp == 2'b11) ? REJ : RUN;
                end
            end
            RUN: begin
                if (finish) begin
                    nextState = IDLE;
                end
            end
            REJ:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        finish    = 1'b0;
        finishErr = 1'b0;
        unique case (state)
            RUN: begin
                if (!fa_stall) begin
                    finish = 1'b1;
                end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
                    finish    = 1'b1;
                    finishErr = 1'b1;
                end
            end
            REJ: begin
                finish    = 1'b1;
                finishErr = 1'b1;
            end
            default: begin
                finish    = 1'b0;
                finishErr = 1'b0;
            end
        endcase
    end

    // Operand latch, watchdog count, result capture and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            res        <= 32'd0;
            err        <= 1'b0;
            fa_u       <= 1'b0;
            fa_v       <= 1'b0;
            fa_x       <= 32'd0;
            fa_y       <= 32'd0;
            grantId    <= 1'b0;
            lastServed <= 1'b1;
            waitCnt    <= 8'd0;
        end else begin
            r0_ack <= finish & ~grantId;
            r1_ack <= finish & grantId;
            if (finish) begin
                err        <= finishErr;
                res        <= finishErr ? 32'd0 : fa_z;
                lastServed <= grantId;
            end
            if (state == IDLE && anyReq) begin
                grantId <= pick;
                fa_x    <= selX;
                fa_y    <= selY;
                fa_u    <= (selOp == 2'b01);
                fa_v    <= (selOp == 2'b10);
                waitCnt <= 8'd0;
            end else if (state == RUN) begin
                waitCnt <= waitCnt + 8'd1;
            end
        end
    end

endmodule
